// File: rtl/svm_window_classifier_if.sv
// svm_window_classifier_if: block stream, coefficient/bias write and score bundle
interface svm_window_classifier_if #(
  parameter int DW   = 32,
  parameter int AW   = 9,
  parameter int SW_W = 11
);
  logic            i_valid;
  logic            i_sof;
  logic [9*DW-1:0] fea_a;
  logic [9*DW-1:0] fea_b;
  logic [9*DW-1:0] fea_c;
  logic [9*DW-1:0] fea_d;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [9*DW-1:0] coef_wdata;
  logic            bias_we;
  logic [DW-1:0]   bias_wdata;
  logic            o_valid;
  logic [DW-1:0]   result;
  logic            is_person;
  logic [SW_W-1:0] sw_id;
  modport master (
    output i_valid, i_sof, fea_a, fea_b, fea_c, fea_d, coef_we, coef_addr, coef_wdata, bias_we, bias_wdata,
    input  o_valid, result, is_person, sw_id
  );
  modport slave (
    input  i_valid, i_sof, fea_a, fea_b, fea_c, fea_d, coef_we, coef_addr, coef_wdata, bias_we, bias_wdata,
    output o_valid, result, is_person, sw_id
  );
endinterface

// File: rtl/svm_window_classifier.sv
// svm_window_classifier: systolic linear-SVM sliding-window scorer; define SVM_SCORE_SAT_EN for saturating adds
module svm_window_classifier #(
  parameter int FEA_I     = 4,
  parameter int FEA_F     = 28,
  parameter int BLK_COLS  = 7,
  parameter int BLK_ROWS  = 15,
  parameter int IMG_BLK_W = 40,
  parameter int SW_W      = 11
) (
  input logic clk,
  input logic rst,
  svm_window_classifier_if.slave bus
);
  localparam int DW = FEA_I + FEA_F;
  localparam int NP = BLK_COLS * BLK_ROWS;
  localparam int NC = NP * 4;
  localparam int LD = IMG_BLK_W - BLK_COLS;
  localparam int CW = $clog2(IMG_BLK_W);
  localparam int RW = BLK_ROWS > 1 ? $clog2(BLK_ROWS) : 1;
  localparam int XW = DW + 7;
  function automatic logic signed [XW-1:0] dot(input logic [36*DW-1:0] f, input logic [36*DW-1:0] w);
    logic signed [2*DW-1:0] p;
    logic signed [DW-1:0] t;
    logic signed [XW-1:0] s;
    s = '0;
    for (int k = 0; k < 36; k++) begin
      p = $signed(f[k*DW +: DW]) * $signed(w[k*DW +: DW]);
      t = DW'(p >>> FEA_F);
      s = s + XW'(t);
    end
    return s;
  endfunction
  function automatic logic [DW-1:0] fit(input logic signed [XW-1:0] v);
`ifdef SVM_SCORE_SAT_EN
    logic signed [XW-1:0] hi, lo;
    hi = (XW'(1) <<< (DW - 1)) - XW'(1);
    lo = -hi - XW'(1);
    return v > hi ? hi[DW-1:0] : v < lo ? lo[DW-1:0] : v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction
  logic [9*DW-1:0]  coef_q [NC];
  logic [DW-1:0]    ps_q [NP-1];
  logic [DW-1:0]    ps_d [NP];
  logic [DW-1:0]    lb_q [BLK_ROWS-1][LD];
  logic [36*DW-1:0] fea;
  logic [CW-1:0]    col_q, beat_col;
  logic [RW-1:0]    row_q, beat_row;
  logic [SW_W-1:0]  cnt_q, beat_cnt, sw_id_q;
  logic [DW-1:0]    bias_q, result_q;
  logic             o_valid_q, win;
  assign fea = {bus.fea_d, bus.fea_c, bus.fea_b, bus.fea_a};
  for (genvar p = 0; p < NP; p++) begin : g_pe
    logic [DW-1:0] pin;
    logic [36*DW-1:0] w;
    assign w = {coef_q[4*p+3], coef_q[4*p+2], coef_q[4*p+1], coef_q[4*p]};
    if (p == 0) begin : g_first
      assign pin = '0;
    end else if (p % BLK_COLS == 0) begin : g_wrap
      assign pin = lb_q[p/BLK_COLS-1][LD-1];
    end else begin : g_chain
      assign pin = ps_q[p-1];
    end
    assign ps_d[p] = fit(XW'($signed(pin)) + dot(fea, w));
  end
  // Position of the current beat; i_sof pins it to the frame origin
  always_comb begin
    beat_col = bus.i_sof ? '0 : col_q;
    beat_row = bus.i_sof ? '0 : row_q;
    beat_cnt = bus.i_sof ? '0 : cnt_q;
    win = bus.i_valid && beat_col >= CW'(BLK_COLS - 1) && beat_row == RW'(BLK_ROWS - 1);
  end
  // Coefficient store survives reset and accepts writes regardless of it
  always_ff @(posedge clk)
    if (bus.coef_we && int'(bus.coef_addr) < NC) coef_q[bus.coef_addr] <= bus.coef_wdata;
  // Partial sums move one PE right per beat; row ends wait in the line buffers
  always_ff @(posedge clk)
    if (!rst) begin
      ps_q <= '{default: '0};
      lb_q <= '{default: '0};
    end else if (bus.i_valid) begin
      for (int i = 0; i < NP - 1; i++) ps_q[i] <= ps_d[i];
      for (int r = 0; r < BLK_ROWS - 1; r++) begin
        lb_q[r][0] <= ps_q[r*BLK_COLS + BLK_COLS - 1];
        for (int i = 1; i < LD; i++) lb_q[r][i] <= lb_q[r][i-1];
      end
    end
  // Beat counters (row saturates once windows are possible), bias and the score register
  always_ff @(posedge clk)
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      bias_q    <= '0;
      o_valid_q <= 1'b0;
      result_q  <= '0;
      sw_id_q   <= '0;
    end else begin
      if (bus.bias_we) bias_q <= bus.bias_wdata;
      o_valid_q <= win;
      if (bus.i_valid) begin
        col_q <= beat_col == CW'(IMG_BLK_W - 1) ? '0 : beat_col + 1'b1;
        row_q <= beat_col == CW'(IMG_BLK_W - 1) && beat_row != RW'(BLK_ROWS - 1) ? beat_row + 1'b1 : beat_row;
        cnt_q <= win ? beat_cnt + 1'b1 : beat_cnt;
      end
      if (win) begin
        result_q <= fit(XW'($signed(ps_d[NP-1])) + XW'($signed(bias_q)));
        sw_id_q  <= beat_cnt;
      end
    end
  assign bus.o_valid   = o_valid_q;
  assign bus.result    = result_q;
  assign bus.is_person = ~result_q[DW-1];
  assign bus.sw_id     = sw_id_q;
endmodule

// File: tb/tb_svm_window_classifier.sv
// tb_svm_window_classifier: directed frames against a window-level score model
module tb_svm_window_classifier;
  localparam int DW = 32;
  localparam int BC = 2;
  localparam int BR = 2;
  localparam int W  = 4;
  localparam int NC = BC * BR * 4;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int mcoef [NC][9];
  int feat [4][W][36];
  int mbias = 0, mcol = 0, mrow = 0, mcnt = 0;
  bit exp_v = 1'b0;
  int exp_res = 0, exp_id = 0;
  svm_window_classifier_if #(.DW(DW), .AW(AW), .SW_W(11)) bus ();
  svm_window_classifier #(.FEA_I(4), .FEA_F(28), .BLK_COLS(BC), .BLK_ROWS(BR), .IMG_BLK_W(W), .SW_W(11))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, expv);
    end
  endtask
  function automatic longint fitm(input longint v);
`ifdef SVM_SCORE_SAT_EN
    longint hi;
    hi = (longint'(1) <<< 31) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
`else
    return longint'(int'(v));
`endif
  endfunction
  function automatic int fval(input int mode, input int x, input int y, input int k);
    return mode == 0 ? 32'h0800_0000 : (((x + 2 * y + k) % 5) - 2) * (1 << 26);
  endfunction
  task automatic step(input bit v, input bit sof, input int mode);
    int bx, by;
    longint acc, d, p;
    logic [36*DW-1:0] fv;
    bx = sof ? 0 : mcol;
    by = sof ? 0 : mrow;
    for (int k = 0; k < 36; k++) fv[k*DW +: DW] = fval(mode, bx, by, k);
    {bus.fea_d, bus.fea_c, bus.fea_b, bus.fea_a} = fv;
    bus.i_valid = v;
    bus.i_sof = sof;
    @(posedge clk);
    exp_v = 1'b0;
    if (!rst) begin
      mcol = 0; mrow = 0; mcnt = 0; mbias = 0;
    end else begin
      if (v) begin
        if (sof) mcnt = 0;
        for (int k = 0; k < 36; k++) feat[by % 4][bx][k] = fval(mode, bx, by, k);
        if (bx >= BC - 1 && by >= BR - 1) begin
          acc = 0;
          for (int r = 0; r < BR; r++)
            for (int c = 0; c < BC; c++) begin
              d = 0;
              for (int k = 0; k < 36; k++) begin
                p = longint'(feat[(by - BR + 1 + r) % 4][bx - BC + 1 + c][k]) * longint'(mcoef[(r * BC + c) * 4 + k / 9][k % 9]);
                d += longint'(int'(p >>> 28));
              end
              acc = fitm(acc + d);
            end
          exp_res = int'(fitm(acc + longint'(mbias)));
          exp_id = mcnt % 2048;
          exp_v = 1'b1;
          mcnt++;
        end
        mcol = bx == W - 1 ? 0 : bx + 1;
        mrow = bx == W - 1 ? by + 1 : by;
      end
      if (bus.bias_we) mbias = int'(bus.bias_wdata);
    end
    if (bus.coef_we) for (int b = 0; b < 9; b++) mcoef[bus.coef_addr][b] = int'(bus.coef_wdata[b*DW +: DW]);
    #1;
    bus.coef_we = 1'b0;
    bus.bias_we = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
  endtask
  task automatic wcoef(input int a, input int val);
    bus.coef_we = 1'b1;
    bus.coef_addr = AW'(a);
    for (int b = 0; b < 9; b++) bus.coef_wdata[b*DW +: DW] = val;
    step(0, 0, 0);
  endtask
  task automatic wbias(input int val);
    bus.bias_we = 1'b1;
    bus.bias_wdata = val;
    step(0, 0, 0);
  endtask
  task automatic frame(input int nb, input bit gaps, input int mode);
    pulses = 0;
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, mode);
      step(1, i == 0, mode);
    end
    step(0, 0, mode);
  endtask
  always @(negedge clk) begin
    chk("o_valid", {31'd0, bus.o_valid}, {31'd0, exp_v});
    if (exp_v) begin
      chk("result", bus.result, exp_res);
      chk("is_person", {31'd0, bus.is_person}, {31'd0, ~exp_res[31]});
      chk("sw_id", {21'd0, bus.sw_id}, exp_id);
    end
    if (bus.o_valid) pulses++;
  end
  initial begin
    bus.i_valid = 0; bus.i_sof = 0; bus.fea_a = '0; bus.fea_b = '0; bus.fea_c = '0; bus.fea_d = '0;
    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_wdata = '0; bus.bias_we = 0; bus.bias_wdata = '0;
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_is_person", {31'd0, bus.is_person}, 32'd1);
    chk("rst_sw_id", {21'd0, bus.sw_id}, 32'd0);
    rst = 1'b1;
    for (int a = 0; a < NC; a++) wcoef(a, 32'h0100_0000);
    wbias(32'hC000_0000);
    frame(12, 0, 0);
    chk("t1_pulses", pulses, 6);
    chk("t1_model", exp_res, 32'h0800_0000);
    chk("t1_result", bus.result, 32'h0800_0000);
    chk("t1_is_person", {31'd0, bus.is_person}, 32'd1);
    chk("t1_last_id", {21'd0, bus.sw_id}, 32'd5);
    wbias(32'hB000_0000);
    frame(12, 1, 0);
    chk("t2_pulses", pulses, 6);
    chk("t2_result", bus.result, 32'hF800_0000);
    chk("t2_is_person", {31'd0, bus.is_person}, 32'd0);
    chk("t2_last_id", {21'd0, bus.sw_id}, 32'd5);
    wbias(32'h7000_0000);
    frame(12, 0, 0);
`ifdef SVM_SCORE_SAT_EN
    chk("t3_result", bus.result, 32'h7FFF_FFFF);
    chk("t3_is_person", {31'd0, bus.is_person}, 32'd1);
`else
    chk("t3_result", bus.result, 32'hB800_0000);
    chk("t3_is_person", {31'd0, bus.is_person}, 32'd0);
`endif
    wbias(32'hC000_0000);
    frame(5, 0, 0);
    chk("t4_pre_pulses", pulses, 0);
    rst = 1'b0;
    bus.bias_we = 1'b1;
    bus.bias_wdata = 32'h7000_0000;
    bus.coef_we = 1'b1;
    bus.coef_addr = AW'(15);
    for (int b = 0; b < 9; b++) bus.coef_wdata[b*DW +: DW] = 32'h0200_0000;
    step(0, 0, 0);
    rst = 1'b1;
    chk("t4_rst_result", bus.result, 32'h0);
    chk("t4_rst_sw_id", {21'd0, bus.sw_id}, 32'd0);
    frame(12, 0, 0);
    chk("t4_pulses", pulses, 6);
    chk("t4_result", bus.result, 32'h4C80_0000);
    wcoef(15, 32'h0100_0000);
    wbias(32'hC000_0000);
    frame(9, 1, 0);
    chk("t5_first_pulses", pulses, 3);
    frame(12, 1, 0);
    chk("t5_pulses", pulses, 6);
    chk("t5_last_id", {21'd0, bus.sw_id}, 32'd5);
    wcoef(0, 32'h0);
    frame(12, 0, 0);
    chk("t6_pulses", pulses, 6);
    for (int a = 0; a < NC; a++) wcoef(a, (((a * 3) % 7) - 3) * (1 << 24));
    wbias(32'h0100_0000);
    frame(12, 1, 1);
    chk("t7_pulses", pulses, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
